adc_temp_filter: RTL and testbench

Per-channel temperature smoothing and over-temperature alarm stage that sits directly downstream of `adc_temps_if`. It consumes each simultaneous A/B conversion pair from the AD7265 interface (8 mux addresses × 2 converters = 16 channels) and keeps a first-order IIR average per channel. It compares each average against global hysteresis thresholds and exposes averages and alarm flags to the register bank.

---
 rtl/adc_temp_filter_pkg.sv | 21 ++
 rtl/adc_temp_filter_if.sv | 24 ++
 rtl/adc_temp_filter_hyst_cmp.sv | 21 ++
 rtl/adc_temp_filter.sv | 163 ++++++++++++++++
 tb/tb_adc_temp_filter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_temp_filter_pkg.sv
// Shared types and constants for the per-channel temperature IIR filter and alarm stage.
package adc_temp_filter_pkg;

  localparam int unsigned SAMPLE_W   = 12;
  localparam int unsigned TEMP_NCHAN = 16;

  typedef logic [3:0]          temp_chan_t;
  typedef logic [SAMPLE_W-1:0] adc_sample_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StProcA = 2'd1,
    StProcB = 2'd2
  } temp_filt_state_t;

  // Converter A occupies channels 0..7, converter B channels 8..15.
  function automatic temp_chan_t temp_chan(input logic sel, input logic [2:0] addr);
    return {sel, addr};
  endfunction

endpackage

// File: rtl/adc_temp_filter_if.sv
// Simultaneous A/B conversion pair bus from the AD7265 front end into the filter.
interface adc_temp_filter_if;
  import adc_temp_filter_pkg::*;

  logic        sample_valid;
  logic [2:0]  sample_addr;
  adc_sample_t sample_a;
  adc_sample_t sample_b;

  modport master (
    output sample_valid,
    output sample_addr,
    output sample_a,
    output sample_b
  );

  modport slave (
    input sample_valid,
    input sample_addr,
    input sample_a,
    input sample_b
  );

endinterface

// File: rtl/adc_temp_filter_hyst_cmp.sv
// Hysteresis comparator: sets above the high level, clears below the low level, else holds.
module temp_hyst_cmp
  import adc_temp_filter_pkg::*;
(
  input  adc_sample_t i_avg,
  input  adc_sample_t i_thresh_hi,
  input  adc_sample_t i_thresh_lo,
  input  logic        i_flag,
  output logic        o_flag
);

  always_comb begin
    o_flag = i_flag;
    if (i_avg > i_thresh_hi) begin
      o_flag = 1'b1;
    end else if (i_avg < i_thresh_lo) begin
      o_flag = 1'b0;
    end
  end

endmodule

// File: rtl/adc_temp_filter.sv
// 16-channel first-order IIR temperature smoother with per-channel hysteresis alarms.
// Each accepted A/B pair is written over two cycles through a single accumulator write port.
module adc_temp_filter
  import adc_temp_filter_pkg::*;
#(
  parameter int unsigned SHIFT = 3
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   soft_reset,
  adc_temp_filter_if.slave       smp_if,
  input  adc_sample_t            thresh_hi,
  input  adc_sample_t            thresh_lo,
  input  temp_chan_t             rd_chan,
  output adc_sample_t            rd_avg,
  output logic                   rd_primed,
  output logic [TEMP_NCHAN-1:0]  alarm,
  output logic                   alarm_any,
  output logic                   busy,
  output logic                   update_done,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int unsigned ACC_W = SAMPLE_W + SHIFT;

  temp_filt_state_t       r_state;
  logic [2:0]             r_addr;
  adc_sample_t            r_a;
  adc_sample_t            r_b;
  logic                   r_update_done;
  logic                   r_overrun;

  logic [ACC_W-1:0]       r_acc [TEMP_NCHAN];
  logic [TEMP_NCHAN-1:0]  r_primed;
  logic [TEMP_NCHAN-1:0]  r_alarm;

  adc_sample_t            r_rd_avg;
  logic                   r_rd_primed;
  logic                   r_alarm_any;

  logic                   w_wr_en;
  logic                   w_sel_b;
  temp_chan_t             w_chan;
  adc_sample_t            w_x;
  logic [ACC_W-1:0]       w_acc_old;
  logic [ACC_W-1:0]       w_acc_new;
  adc_sample_t            w_avg_new;
  logic                   w_alarm_new;

  // Control FSM: capture a pair in idle, then spend one cycle per converter channel.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state       <= StIdle;
      r_addr        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_update_done <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (soft_reset) begin
      r_state       <= StIdle;
      r_addr        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_update_done <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_update_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (smp_if.sample_valid) begin
            r_addr  <= smp_if.sample_addr;
            r_a     <= smp_if.sample_a;
            r_b     <= smp_if.sample_b;
            r_state <= StProcA;
          end
        end
        StProcA: r_state <= StProcB;
        StProcB: begin
          r_state       <= StIdle;
          r_update_done <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
      // A fresh overrun wins over a simultaneous clear.
      if (smp_if.sample_valid && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign w_wr_en   = (r_state == StProcA) || (r_state == StProcB);
  assign w_sel_b   = (r_state == StProcB);
  assign w_chan    = temp_chan(w_sel_b, r_addr);
  assign w_x       = w_sel_b ? r_b : r_a;
  assign w_acc_old = r_acc[w_chan];

  // acc holds avg scaled by 2^SHIFT, so it never exceeds 4095 << SHIFT and cannot overflow.
  always_comb begin
    w_acc_new = ACC_W'(w_x) << SHIFT;
    if (r_primed[w_chan]) begin
      w_acc_new = w_acc_old - (w_acc_old >> SHIFT) + ACC_W'(w_x);
    end
  end

  assign w_avg_new = SAMPLE_W'(w_acc_new >> SHIFT);

  temp_hyst_cmp u_hyst_cmp (
    .i_avg       (w_avg_new),
    .i_thresh_hi (thresh_hi),
    .i_thresh_lo (thresh_lo),
    .i_flag      (r_alarm[w_chan]),
    .o_flag      (w_alarm_new)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < TEMP_NCHAN; i++) begin
        r_acc[i] <= '0;
      end
      r_primed <= '0;
      r_alarm  <= '0;
    end else if (soft_reset) begin
      for (int unsigned i = 0; i < TEMP_NCHAN; i++) begin
        r_acc[i] <= '0;
      end
      r_primed <= '0;
      r_alarm  <= '0;
    end else if (w_wr_en) begin
      r_acc[w_chan]    <= w_acc_new;
      r_primed[w_chan] <= 1'b1;
      r_alarm[w_chan]  <= w_alarm_new;
    end
  end

  // Read port and alarm summary are registered one cycle behind the array.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_rd_avg    <= '0;
      r_rd_primed <= 1'b0;
      r_alarm_any <= 1'b0;
    end else if (soft_reset) begin
      r_rd_avg    <= '0;
      r_rd_primed <= 1'b0;
      r_alarm_any <= 1'b0;
    end else begin
      r_rd_avg    <= SAMPLE_W'(r_acc[rd_chan] >> SHIFT);
      r_rd_primed <= r_primed[rd_chan];
      r_alarm_any <= |r_alarm;
    end
  end

  assign rd_avg      = r_rd_avg;
  assign rd_primed   = r_rd_primed;
  assign alarm       = r_alarm;
  assign alarm_any   = r_alarm_any;
  assign busy        = (r_state != StIdle);
  assign update_done = r_update_done;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_adc_temp_filter.sv
// Bench for adc_temp_filter: SHIFT=0 and SHIFT=3 instances share one stimulus stream.
module tb_adc_temp_filter;
  import adc_temp_filter_pkg::*;

  logic              clock;
  logic              nreset;
  logic              soft_reset;
  logic              overrun_clr;
  adc_sample_t       thresh_hi;
  adc_sample_t       thresh_lo;
  temp_chan_t        rd_chan;
  logic [1:0][11:0]  rd_avg;
  logic [1:0]        rd_primed;
  logic [1:0][15:0]  alarm;
  logic [1:0]        alarm_any;
  logic [1:0]        busy;
  logic [1:0]        update_done;
  logic [1:0]        overrun;

  adc_temp_filter_if smp_if ();

  adc_temp_filter #(.SHIFT(0)) u_dut0 (
    .clock       (clock),
    .nreset      (nreset),
    .soft_reset  (soft_reset),
    .smp_if      (smp_if),
    .thresh_hi   (thresh_hi),
    .thresh_lo   (thresh_lo),
    .rd_chan     (rd_chan),
    .rd_avg      (rd_avg[0]),
    .rd_primed   (rd_primed[0]),
    .alarm       (alarm[0]),
    .alarm_any   (alarm_any[0]),
    .busy        (busy[0]),
    .update_done (update_done[0]),
    .overrun     (overrun[0]),
    .overrun_clr (overrun_clr)
  );

  adc_temp_filter #(.SHIFT(3)) u_dut3 (
    .clock       (clock),
    .nreset      (nreset),
    .soft_reset  (soft_reset),
    .smp_if      (smp_if),
    .thresh_hi   (thresh_hi),
    .thresh_lo   (thresh_lo),
    .rd_chan     (rd_chan),
    .rd_avg      (rd_avg[1]),
    .rd_primed   (rd_primed[1]),
    .alarm       (alarm[1]),
    .alarm_any   (alarm_any[1]),
    .busy        (busy[1]),
    .update_done (update_done[1]),
    .overrun     (overrun[1]),
    .overrun_clr (overrun_clr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $error("FAIL watchdog: observed no end of run, required completion before time limit");
    $fatal(1);
  end

  // Reference model, index 0 is SHIFT=0 and index 1 is SHIFT=3.
  int unsigned m_acc [2][16];
  logic [15:0] m_pr [2];
  logic [15:0] m_al [2];
  int          n_cmp;
  int          n_bad;
  logic [11:0] step_exp [3];
  logic        hyst_exp [3];
  logic [11:0] hyst_in [3];

  function automatic int unsigned m_shift(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic int unsigned m_avg(input int k, input int ch);
    return m_acc[k][ch] / (1 << m_shift(k));
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 16; c++) m_acc[k][c] = 0;
      m_pr[k] = '0;
      m_al[k] = '0;
    end
  endfunction

  function automatic void m_update(input int k, input int ch, input int unsigned x);
    int unsigned scale;
    scale = 1 << m_shift(k);
    if (!m_pr[k][ch]) m_acc[k][ch] = x * scale;
    else m_acc[k][ch] = m_acc[k][ch] - m_acc[k][ch] / scale + x;
    m_pr[k][ch] = 1'b1;
    if (m_avg(k, ch) > int'(thresh_hi)) m_al[k][ch] = 1'b1;
    else if (m_avg(k, ch) < int'(thresh_lo)) m_al[k][ch] = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s rd_avg d%0d", tag, k), 32'(rd_avg[k]), 0);
      chk($sformatf("%s rd_primed d%0d", tag, k), 32'(rd_primed[k]), 0);
      chk($sformatf("%s alarm d%0d", tag, k), 32'(alarm[k]), 0);
      chk($sformatf("%s alarm_any d%0d", tag, k), 32'(alarm_any[k]), 0);
      chk($sformatf("%s busy d%0d", tag, k), 32'(busy[k]), 0);
      chk($sformatf("%s update_done d%0d", tag, k), 32'(update_done[k]), 0);
      chk($sformatf("%s overrun d%0d", tag, k), 32'(overrun[k]), 0);
    end
  endtask

  task automatic chk_read(input int ch);
    rd_chan = 4'(ch);
    @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_avg d%0d ch%0d", k, ch), 32'(rd_avg[k]), m_avg(k, ch));
      chk($sformatf("rd_primed d%0d ch%0d", k, ch), 32'(rd_primed[k]), 32'(m_pr[k][ch]));
    end
  endtask

  // Called at a falling edge; returns at a falling edge after the pair has fully retired.
  task automatic send_pair(input logic [2:0] addr, input logic [11:0] a, input logic [11:0] b);
    logic [1:0] any_pre, any_mid, any_post;
    smp_if.sample_valid = 1'b1;
    smp_if.sample_addr  = addr;
    smp_if.sample_a     = a;
    smp_if.sample_b     = b;
    @(posedge clock);
    @(negedge clock);
    smp_if.sample_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      any_pre[k] = |m_al[k];
      chk($sformatf("busy1 d%0d", k), 32'(busy[k]), 1);
      chk($sformatf("done0 d%0d", k), 32'(update_done[k]), 0);
      m_update(k, {1'b0, addr}, a);
      any_mid[k] = |m_al[k];
    end
    @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("alarmA d%0d", k), 32'(alarm[k]), 32'(m_al[k]));
      chk($sformatf("anyA d%0d", k), 32'(alarm_any[k]), 32'(any_pre[k]));
      chk($sformatf("busy2 d%0d", k), 32'(busy[k]), 1);
      m_update(k, {1'b1, addr}, b);
      any_post[k] = |m_al[k];
    end
    @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("alarmB d%0d", k), 32'(alarm[k]), 32'(m_al[k]));
      chk($sformatf("anyB d%0d", k), 32'(alarm_any[k]), 32'(any_mid[k]));
      chk($sformatf("done1 d%0d", k), 32'(update_done[k]), 1);
      chk($sformatf("busy3 d%0d", k), 32'(busy[k]), 0);
    end
    @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done2 d%0d", k), 32'(update_done[k]), 0);
      chk($sformatf("anyC d%0d", k), 32'(alarm_any[k]), 32'(any_post[k]));
    end
  endtask

  initial begin
    logic [2:0]  ad;
    logic [11:0] va, vb;
    n_cmp = 0;
    n_bad = 0;
    step_exp = '{12'h100, 12'h1E0, 12'h2A4};
    hyst_in  = '{12'h900, 12'h780, 12'h6F0};
    hyst_exp = '{1'b1, 1'b1, 1'b0};
    nreset = 1'b0;
    soft_reset = 1'b0;
    overrun_clr = 1'b0;
    thresh_hi = 12'hFFF;
    thresh_lo = 12'h000;
    rd_chan = '0;
    smp_if.sample_valid = 1'b0;
    smp_if.sample_addr = '0;
    smp_if.sample_a = '0;
    smp_if.sample_b = '0;
    m_reset();
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    nreset = 1'b1;
    @(negedge clock);

    // Seed pair
    send_pair(3'd1, 12'h012, 12'hFED);
    chk_read(1);
    chk("seed a", 32'(rd_avg[1]), 32'h012);
    chk_read(9);
    chk("seed b", 32'(rd_avg[1]), 32'hFED);

    // Step response
    send_pair(3'd2, 12'h000, 12'($urandom_range(0, 4095)));
    for (int i = 0; i < 3; i++) begin
      send_pair(3'd2, 12'h800, 12'($urandom_range(0, 4095)));
      chk_read(2);
      chk($sformatf("step %0d", i), 32'(rd_avg[1]), 32'(step_exp[i]));
    end

    // Hysteresis
    thresh_hi = 12'h800;
    thresh_lo = 12'h700;
    for (int i = 0; i < 3; i++) begin
      send_pair(3'd3, hyst_in[i], 12'($urandom_range(0, 4095)));
      chk($sformatf("hyst %0d", i), 32'(alarm[0][3]), 32'(hyst_exp[i]));
    end

    // Overrun: second strobe one cycle after the first is dropped
    smp_if.sample_valid = 1'b1;
    smp_if.sample_addr = 3'd4;
    smp_if.sample_a = 12'h123;
    smp_if.sample_b = 12'h456;
    @(posedge clock);
    @(negedge clock);
    smp_if.sample_addr = 3'd5;
    smp_if.sample_a = 12'hABC;
    smp_if.sample_b = 12'hDEF;
    for (int k = 0; k < 2; k++) m_update(k, 4, 12'h123);
    @(posedge clock);
    @(negedge clock);
    smp_if.sample_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("overrun set d%0d", k), 32'(overrun[k]), 1);
      m_update(k, 12, 12'h456);
    end
    repeat (2) @(negedge clock);
    chk_read(4);
    chk_read(12);
    chk_read(5);
    chk_read(13);

    // A fresh overrun beats a simultaneous clear
    smp_if.sample_valid = 1'b1;
    smp_if.sample_addr = 3'd4;
    smp_if.sample_a = 12'h321;
    smp_if.sample_b = 12'h654;
    @(posedge clock);
    @(negedge clock);
    overrun_clr = 1'b1;
    smp_if.sample_addr = 3'd5;
    for (int k = 0; k < 2; k++) begin
      m_update(k, 4, 12'h321);
      m_update(k, 12, 12'h654);
    end
    @(posedge clock);
    @(negedge clock);
    smp_if.sample_valid = 1'b0;
    overrun_clr = 1'b0;
    for (int k = 0; k < 2; k++) chk($sformatf("overrun hold d%0d", k), 32'(overrun[k]), 1);
    repeat (2) @(negedge clock);
    overrun_clr = 1'b1;
    @(posedge clock);
    @(negedge clock);
    overrun_clr = 1'b0;
    for (int k = 0; k < 2; k++) chk($sformatf("overrun clr d%0d", k), 32'(overrun[k]), 0);
    chk_read(4);
    chk_read(12);
    chk_read(5);

    // Soft reset in PROC_A discards the pair
    smp_if.sample_valid = 1'b1;
    smp_if.sample_addr = 3'd6;
    smp_if.sample_a = 12'h111;
    smp_if.sample_b = 12'h222;
    @(posedge clock);
    @(negedge clock);
    smp_if.sample_valid = 1'b0;
    soft_reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    soft_reset = 1'b0;
    m_reset();
    chk_all_zero("soft_reset");
    chk_read(6);
    chk_read(14);
    chk_read(1);

    // Asynchronous nreset pulse between edges, same scenario
    send_pair(3'd1, 12'h0F0, 12'hF0F);
    smp_if.sample_valid = 1'b1;
    smp_if.sample_addr = 3'd6;
    smp_if.sample_a = 12'h333;
    smp_if.sample_b = 12'h444;
    @(posedge clock);
    @(negedge clock);
    smp_if.sample_valid = 1'b0;
    #1 nreset = 1'b0;
    #1 chk_all_zero("nreset low");
    #1 nreset = 1'b1;
    m_reset();
    @(negedge clock);
    chk_all_zero("nreset after");
    chk_read(6);
    chk_read(14);
    chk_read(1);

    // Soak against the model at 16-cycle pair spacing
    for (int i = 0; i < 1000; i++) begin
      if (i % 40 == 0) begin
        thresh_lo = 12'($urandom_range(0, 4095));
        thresh_hi = 12'($urandom_range(int'(thresh_lo), 4095));
      end
      ad = 3'($urandom_range(0, 7));
      va = 12'($urandom_range(0, 4095));
      vb = 12'($urandom_range(0, 4095));
      send_pair(ad, va, vb);
      chk_read({1'b0, ad});
      chk_read({1'b1, ad});
      repeat (10) @(negedge clock);
    end
    for (int k = 0; k < 2; k++) chk($sformatf("soak overrun d%0d", k), 32'(overrun[k]), 0);
    for (int c = 0; c < 16; c++) chk_read(c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
